// File: rtl/uart_pkg.sv
// Shared UART types: FSM state encoding, parity modes, parity helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package uart_pkg;

  // Widest payload any UART in this codebase carries; parity helpers take
  // data zero-extended to this width (zero bits do not affect XOR parity).
  localparam int MAX_DATA_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  // Raw 2-bit config to parity mode; the unused code 11 behaves as none.
  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  // Even parity bit = XOR of the data, odd = its complement.
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                       input parity_e mode);
    if (mode == PAR_ODD) return ~^data;
    else                 return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous DATA_W x DEPTH FIFO with occupancy count, full and empty flags.
// Latency: a push into an empty FIFO shows on rd_data/empty the next cycle.
// Backpressure: pushes while full and pops while empty are ignored; a same-cycle pop never frees space for a push.
// Ports: clk, rst (sync, active high); wr_en/wr_data push side;
//        rd_en/rd_data pop side (rd_data is the current head); count/full/empty status.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         rd_en,
  output logic [DATA_W-1:0]            rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (5..9 data bits, none/even/odd parity, 1/2 stop) fed by a write FIFO.
// Latency: tx changes the cycle after the baud_trig that selects each bit; frames run back-to-back.
// Backpressure: wr_ready = !full; a write while full is dropped and flagged by a one-cycle overflow pulse.
// Ports: clk, rst (sync, active high); wr_en/data_in/wr_ready host write side;
//        baud_trig bit pacing; parity_mode/stop2 frame config (latched per frame);
//        tx serial out; done_tx/busy/fifo_count/overflow status.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [DATA_W-1:0]                 data_in,
  output logic                              wr_ready,
  input  logic                              baud_trig,
  input  logic [1:0]                        parity_mode,
  input  logic                              stop2,
  output logic                              tx,
  output logic                              done_tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow
);

  localparam int CNT_W = $clog2(DATA_W+1);

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              pop;

  tx_state_e         state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic              stop_cnt, stop_cnt_n;
  logic              par_bit, par_bit_n;
  logic              par_en, par_en_n;
  logic              stop2_q, stop2_n;
  logic              tx_q, tx_n;
  logic              start_frame;
  parity_e           par_mode;

  uart_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign par_mode = decode_parity(parity_mode);
  assign wr_ready = !fifo_full;
  assign tx       = tx_q;
  assign busy     = (state != ST_IDLE);
  assign done_tx  = (state == ST_IDLE) && fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
      par_en   <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      par_bit  <= par_bit_n;
      par_en   <= par_en_n;
      stop2_q  <= stop2_n;
      tx_q     <= tx_n;
      // Registered: pulses the cycle after the dropped write.
      overflow <= wr_en && fifo_full;
    end
  end

  // tx_n is the value tx will hold for the next bit interval; the state names
  // the bit being held, so e.g. ST_DATA with bit_cnt==k holds data[k-1].
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    bit_cnt_n   = bit_cnt;
    stop_cnt_n  = stop_cnt;
    par_bit_n   = par_bit;
    par_en_n    = par_en;
    stop2_n     = stop2_q;
    tx_n        = tx_q;
    start_frame = 1'b0;

    if (baud_trig) begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) start_frame = 1'b1;
        end
        ST_START: begin
          tx_n      = shreg[0];
          shreg_n   = shreg >> 1;
          bit_cnt_n = CNT_W'(1);
          state_n   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt == CNT_W'(DATA_W)) begin
            if (par_en) begin
              tx_n    = par_bit;
              state_n = ST_PARITY;
            end else begin
              tx_n       = 1'b1;
              stop_cnt_n = 1'b0;
              state_n    = ST_STOP;
            end
          end else begin
            tx_n      = shreg[0];
            shreg_n   = shreg >> 1;
            bit_cnt_n = bit_cnt + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          tx_n       = 1'b1;
          stop_cnt_n = 1'b0;
          state_n    = ST_STOP;
        end
        ST_STOP: begin
          if (stop2_q && !stop_cnt) begin
            stop_cnt_n = 1'b1;
          end else if (!fifo_empty) begin
            start_frame = 1'b1;
          end else begin
            tx_n    = 1'b1;
            state_n = ST_IDLE;
          end
        end
        default: begin
          tx_n    = 1'b1;
          state_n = ST_IDLE;
        end
      endcase
    end

    // Frame start: pop the head and freeze this frame's config and parity.
    if (start_frame) begin
      shreg_n   = fifo_head;
      par_en_n  = (par_mode != PAR_NONE);
      par_bit_n = calc_parity(MAX_DATA_W'(fifo_head), par_mode);
      stop2_n   = stop2;
      tx_n      = 1'b0;
      state_n   = ST_START;
    end
  end

  assign pop = start_frame;

endmodule
